// File: rtl/serial_pkg.sv
// Shared definitions for the serial bit-stream blocks (serializer and the
// downstream bit-pattern detectors and their benches).
package serial_pkg;

  // Serializer FSM encoding; kept one bit wide so busy is the state bit.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } serial_state_t;

  // Level the serial line rests at between words.
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out stage. Words arrive over valid/ready and leave one
// bit per clock; the line sits at IDLE_BIT between words and back-to-back
// words stream with no gap.
//
//   state    | meaning
//   ST_IDLE  | line at IDLE_BIT, ready for a word
//   ST_SHIFT | emitting bits of the current word, r_cnt = index of bit on the line
module piso_serializer
  import serial_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = IDLE_LEVEL
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  serial_state_t    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_serial_out;
  logic             r_serial_valid;
  logic             r_frame_start;

  logic             w_ready;
  logic             w_transfer;
  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_load_shift;
  logic [WIDTH-1:0] w_step_shift;

  // The shift register holds only the bits not yet on the line, so the
  // outgoing bit is always at the edge of r_shift.
  assign w_first_bit  = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
  assign w_load_shift = MSB_FIRST ? {data_in[WIDTH-2:0], 1'b0}
                                  : {1'b0, data_in[WIDTH-1:1]};
  assign w_next_bit   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  assign w_step_shift = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                  : {1'b0, r_shift[WIDTH-1:1]};
  assign w_transfer   = data_valid && w_ready;

  // Ready in idle, or on the last bit of a word so the next one follows without a gap.
  always_comb begin
    w_ready = 1'b0;
    if (r_state == ST_IDLE) begin
      w_ready = 1'b1;
    end else if (r_cnt == LAST_CNT) begin
      w_ready = 1'b1;
    end
  end

  // FSM, bit counter, shift register and registered serial outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_shift        <= '0;
      r_serial_out   <= IDLE_BIT;
      r_serial_valid <= 1'b0;
      r_frame_start  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_transfer) begin
            r_state        <= ST_SHIFT;
            r_cnt          <= '0;
            r_shift        <= w_load_shift;
            r_serial_out   <= w_first_bit;
            r_serial_valid <= 1'b1;
            r_frame_start  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (r_cnt != LAST_CNT) begin
            r_cnt          <= r_cnt + 1'b1;
            r_shift        <= w_step_shift;
            r_serial_out   <= w_next_bit;
            r_frame_start  <= 1'b0;
          end else if (w_transfer) begin
            r_cnt          <= '0;
            r_shift        <= w_load_shift;
            r_serial_out   <= w_first_bit;
            r_serial_valid <= 1'b1;
            r_frame_start  <= 1'b1;
          end else begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_serial_out   <= IDLE_BIT;
            r_serial_valid <= 1'b0;
            r_frame_start  <= 1'b0;
          end
        end
        default: begin
          r_state        <= ST_IDLE;
          r_cnt          <= '0;
          r_serial_out   <= IDLE_BIT;
          r_serial_valid <= 1'b0;
          r_frame_start  <= 1'b0;
        end
      endcase
    end
  end

  assign data_ready   = w_ready;
  assign serial_out   = r_serial_out;
  assign serial_valid = r_serial_valid;
  assign frame_start  = r_frame_start;
  assign busy         = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an 8-bit MSB-first instance and a 4-bit
// LSB-first instance share clock and reset. Expected bits are queued when a
// word is offered and popped whenever the DUT marks a bit valid.
module tb_piso_serializer;

  typedef struct {
    logic b;
    logic fs;
  } exp_t;

  typedef struct {
    logic [7:0] w8;
    logic [3:0] w4;
    logic [7:0] seq8;   // transmit order, seq8[7] first on the line
    logic [3:0] seq4;   // transmit order, seq4[3] first on the line
  } vec_t;

  logic       clock;
  logic       rst_n;
  logic [7:0] d8;
  logic       dv8, rdy8, sout8, sv8, fs8, busy8;
  logic [3:0] d4;
  logic       dv4, rdy4, sout4, sv4, fs4, busy4;

  exp_t q8[$];
  exp_t q4[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut8 (
    .clock(clock), .reset(rst_n), .data_in(d8), .data_valid(dv8),
    .data_ready(rdy8), .serial_out(sout8), .serial_valid(sv8),
    .frame_start(fs8), .busy(busy8)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut4 (
    .clock(clock), .reset(rst_n), .data_in(d4), .data_valid(dv4),
    .data_ready(rdy4), .serial_out(sout4), .serial_valid(sv4),
    .frame_start(fs4), .busy(busy4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push8(input logic [7:0] seq);
    exp_t e;
    for (int i = 7; i >= 0; i--) begin
      e.b  = seq[i];
      e.fs = (i == 7);
      q8.push_back(e);
    end
  endtask

  task automatic push4(input logic [3:0] seq);
    exp_t e;
    for (int i = 3; i >= 0; i--) begin
      e.b  = seq[i];
      e.fs = (i == 3);
      q4.push_back(e);
    end
  endtask

  // Scoreboard monitor: pop on every valid bit, otherwise expect an idle line.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (rst_n === 1'b1) begin
      if (sv8 === 1'b1) begin
        if (q8.size() == 0) begin
          check("w8_unexpected_bit", 1, 0);
        end else begin
          e = q8.pop_front();
          check("w8_bit", sout8, e.b);
          check("w8_frame_start", fs8, e.fs);
          check("w8_busy", busy8, 1);
        end
      end else begin
        check("w8_idle_level", sout8, 1);
        check("w8_idle_fs", fs8, 0);
        check("w8_idle_busy", busy8, 0);
      end
      if (sv4 === 1'b1) begin
        if (q4.size() == 0) begin
          check("w4_unexpected_bit", 1, 0);
        end else begin
          e = q4.pop_front();
          check("w4_bit", sout4, e.b);
          check("w4_frame_start", fs4, e.fs);
          check("w4_busy", busy4, 1);
        end
      end else begin
        check("w4_idle_level", sout4, 1);
        check("w4_idle_fs", fs4, 0);
        check("w4_idle_busy", busy4, 0);
      end
    end
  end

  vec_t vecs[4];

  initial begin
    int nvalid;
    int run;

    vecs[0] = '{w8: 8'h01, w4: 4'b0011, seq8: 8'h01, seq4: 4'b1100};
    vecs[1] = '{w8: 8'h80, w4: 4'b1010, seq8: 8'h80, seq4: 4'b0101};
    vecs[2] = '{w8: 8'h3C, w4: 4'b0111, seq8: 8'h3C, seq4: 4'b1110};
    vecs[3] = '{w8: 8'hE7, w4: 4'b1000, seq8: 8'hE7, seq4: 4'b0001};

    // Reset held 3 clocks with a word offered: nothing may be accepted.
    rst_n = 1'b0;
    dv8 = 1'b1; d8 = 8'hC3;
    dv4 = 1'b0; d4 = 4'h0;
    repeat (3) step();
    check("rst_serial_out", sout8, 1);
    check("rst_serial_valid", sv8, 0);
    check("rst_frame_start", fs8, 0);
    check("rst_busy", busy8, 0);
    check("rst_data_ready", rdy8, 1);
    check("rst_w4_serial_out", sout4, 1);
    rst_n = 1'b1;
    dv8 = 1'b0;
    step();
    check("post_rst_no_xfer", sv8, 0);
    check("post_rst_ready", rdy8, 1);

    // Single word A5, offered for one cycle; data_in goes X afterwards.
    d8 = 8'hA5; dv8 = 1'b1;
    push8(8'b1010_0101);
    step();
    dv8 = 1'b0; d8 = 'x;
    check("a5_first_fs", fs8, 1);
    check("a5_first_ready", rdy8, 0);
    for (int k = 2; k <= 8; k++) begin
      step();
      check("a5_ready", rdy8, (k == 8));
    end
    step();
    check("a5_end_valid", sv8, 0);
    check("a5_end_level", sout8, 1);
    check("a5_queue_empty", q8.size(), 0);

    // X on data_in with valid low while idle.
    repeat (3) step();
    check("x_idle_level", sout8, 1);

    // Back-to-back 00 then FF with valid held across the word boundary.
    d8 = 8'h00; dv8 = 1'b1;
    push8(8'h00);
    nvalid = 0;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 1) begin
        d8 = 8'hFF;
        push8(8'hFF);
      end
      if (k == 9) dv8 = 1'b0;
      check("b2b_ready", rdy8, (k == 8 || k == 16 || k == 17));
      if (k == 9) check("b2b_second_fs", fs8, 1);
      if (sv8 === 1'b1) nvalid++;
    end
    check("b2b_valid_cycles", nvalid, 16);
    check("b2b_queue_empty", q8.size(), 0);

    // Three-zero detector on the serial line fed with word 00.
    d8 = 8'h00; dv8 = 1'b1;
    push8(8'h00);
    run = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) dv8 = 1'b0;
      run = (sout8 === 1'b0) ? run + 1 : 0;
      check("tzd_indicator", (run >= 3), (k >= 3 && k <= 8));
    end

    // Reset pulse while bit 3 of F0 is on the line.
    d8 = 8'hF0; dv8 = 1'b1;
    push8(8'hF0);
    step();
    dv8 = 1'b0;
    repeat (3) step();
    check("rstmid_bit3_valid", sv8, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", sv8, 0);
    check("rstmid_level", sout8, 1);
    check("rstmid_fs", fs8, 0);
    check("rstmid_busy", busy8, 0);
    q8.delete();
    step();
    rst_n = 1'b1;
    step();
    check("rstmid_after_valid", sv8, 0);
    d8 = 8'h3C; dv8 = 1'b1;
    push8(8'h3C);
    step();
    dv8 = 1'b0;
    repeat (8) step();
    check("rstmid_next_word_done", q8.size(), 0);
    check("rstmid_next_idle", sv8, 0);

    // LSB-first 4-bit instance, word 0001.
    d4 = 4'b0001; dv4 = 1'b1;
    push4(4'b1000);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) begin
        dv4 = 1'b0; d4 = 'x;
      end
      check("w4_ready", rdy4, (k >= 4));
    end
    check("w4_queue_empty", q4.size(), 0);

    // Table of single words on both instances at once.
    for (int i = 0; i < 4; i++) begin
      d8 = vecs[i].w8; d4 = vecs[i].w4;
      dv8 = 1'b1; dv4 = 1'b1;
      check("tbl_ready8", rdy8, 1);
      check("tbl_ready4", rdy4, 1);
      push8(vecs[i].seq8);
      push4(vecs[i].seq4);
      step();
      dv8 = 1'b0; dv4 = 1'b0;
      d8 = 'x; d4 = 'x;
      repeat (9) step();
      check("tbl_q8_empty", q8.size(), 0);
      check("tbl_q4_empty", q4.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
